// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, single-outstanding ibus fetch, in-order prefetch queue feeding IF/ID.
// Latency: grant n -> inst_valid_o n+2. Stops requesting when the queue is full. Hold freezes the head.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_flag_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o
);
   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL     = (PW+1)'(DEPTH);
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   faddr_q, faddr_d;
   logic          out_q, out_d;
   logic          drop_q, drop_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   addr_mem_q [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];

   logic req, grant, push, pop;
   logic unused_jump_lsb;

   assign unused_jump_lsb = ^jump_addr_i[1:0];

   // Only one request in flight, so count < DEPTH alone guarantees room for its response.
   assign req   = !rst && !out_q && (count_q < FULL) && !jump_flag_i;
   assign grant = req && ibus_gnt_i;
   assign push  = ibus_rvalid_i && !drop_q && !jump_flag_i;
   assign pop   = (count_q != '0) && !hold_flag_i && !jump_flag_i;

   always_comb begin
      pc_d     = pc_q;
      faddr_d  = faddr_q;
      out_d    = out_q;
      drop_d   = drop_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      if (grant) begin
         pc_d    = pc_q + 32'd4;
         faddr_d = pc_q;
         out_d   = 1'b1;
      end
      if (ibus_rvalid_i) begin
         out_d  = 1'b0;
         drop_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;

      // A request still in flight at redirect time returns stale data; mark it for discard.
      if (jump_flag_i) begin
         pc_d     = {jump_addr_i[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         drop_d   = out_q && !ibus_rvalid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         faddr_q  <= '0;
         out_q    <= 1'b0;
         drop_q   <= 1'b0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         faddr_q  <= faddr_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= faddr_q;
         data_mem_q[wr_ptr_q] <= ibus_rdata_i;
      end
   end

   assign ibus_req_o   = req;
   assign ibus_addr_o  = pc_q;
   assign inst_valid_o = (count_q != '0);
   assign inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : 32'h0;
   assign inst_o       = inst_valid_o ? data_mem_q[rd_ptr_q] : INST_NOP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: bus models answer with data = addr>>2; scoreboards check grants and consumed instructions.
module tb_if_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, hold, jump, gnt0;
   logic [31:0] jaddr;
   logic        req0, rvalid0, vld0;
   logic [31:0] addr0, rdata0, iaddr0, inst0;
   logic        rst1;
   logic        req1, rvalid1, vld1;
   logic [31:0] addr1, rdata1, iaddr1, inst1;
   int          rlat;

   int total = 0;
   int bad   = 0;
   int n_cons0 = 0;
   int n_cons1 = 0;
   ent_t        exp0[$];
   ent_t        exp1[$];
   logic [31:0] expg0[$];
   logic [31:0] expg1[$];

   logic [31:0] b_addr;
   int          b_wcnt;
   bit          b_busy;

   always #5 clk = ~clk;

   if_fetch_unit dut0 (
      .clk(clk), .rst(rst), .hold_flag_i(hold), .jump_flag_i(jump), .jump_addr_i(jaddr),
      .ibus_req_o(req0), .ibus_addr_o(addr0), .ibus_gnt_i(gnt0),
      .ibus_rvalid_i(rvalid0), .ibus_rdata_i(rdata0),
      .inst_valid_o(vld0), .inst_addr_o(iaddr0), .inst_o(inst0)
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut1 (
      .clk(clk), .rst(rst1), .hold_flag_i(1'b0), .jump_flag_i(1'b0), .jump_addr_i(32'h0),
      .ibus_req_o(req1), .ibus_addr_o(addr1), .ibus_gnt_i(1'b1),
      .ibus_rvalid_i(rvalid1), .ibus_rdata_i(rdata1),
      .inst_valid_o(vld1), .inst_addr_o(iaddr1), .inst_o(inst1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cons(input int which, input int n);
      int k;
      k = 0;
      while (((which == 0) ? n_cons0 : n_cons1) < n && k < 60) begin
         tick();
         k++;
      end
      total++;
      if (((which == 0) ? n_cons0 : n_cons1) < n) begin
         bad++;
         $display("FAIL wait_cons%0d consumed=%0d required=%0d", which, (which == 0) ? n_cons0 : n_cons1, n);
      end
   endtask

   task automatic chk_rst0(input string tag);
      check({tag, "_vld"},  32'(vld0), 32'd0);
      check({tag, "_addr"}, iaddr0,    32'd0);
      check({tag, "_inst"}, inst0,     NOP);
      check({tag, "_req"},  32'(req0), 32'd0);
   endtask

   task automatic chk_rst1(input string tag);
      check({tag, "_vld"},  32'(vld1), 32'd0);
      check({tag, "_addr"}, iaddr1,    32'd0);
      check({tag, "_inst"}, inst1,     NOP);
      check({tag, "_req"},  32'(req1), 32'd0);
   endtask

   task automatic push0(input logic [31:0] a);
      ent_t e;
      e.a = a;
      e.d = a >> 2;
      exp0.push_back(e);
   endtask

   // Bus model for dut0: grant from gnt0, response rlat cycles after the grant cycle.
   initial begin
      logic g, r;
      logic [31:0] a;
      rvalid0 = 1'b0;
      rdata0  = 32'h0;
      b_busy  = 1'b0;
      b_wcnt  = 0;
      b_addr  = 32'h0;
      forever begin
         @(posedge clk);
         g = req0 && gnt0;
         a = addr0;
         r = rst;
         #1;
         rvalid0 = 1'b0;
         if (r) begin
            b_busy = 1'b0;
         end else begin
            if (b_busy) begin
               b_wcnt = b_wcnt - 1;
               if (b_wcnt == 0) begin
                  rvalid0 = 1'b1;
                  rdata0  = b_addr >> 2;
                  b_busy  = 1'b0;
               end
            end
            if (g) begin
               if (rlat <= 1) begin
                  rvalid0 = 1'b1;
                  rdata0  = a >> 2;
               end else begin
                  b_busy = 1'b1;
                  b_addr = a;
                  b_wcnt = rlat - 1;
               end
            end
         end
      end
   end

   initial begin
      logic g;
      logic [31:0] a;
      rvalid1 = 1'b0;
      rdata1  = 32'h0;
      forever begin
         @(posedge clk);
         g = req1;
         a = addr1;
         #1;
         rvalid1 = g;
         rdata1  = a >> 2;
      end
   end

   // Monitors: consumed instructions and granted fetch addresses against the scoreboards.
   initial begin
      ent_t e;
      logic [31:0] ga;
      forever begin
         @(negedge clk);
         if (!rst && vld0 && !hold && !jump) begin
            n_cons0++;
            if (exp0.size() == 0) begin
               total++; bad++;
               $display("FAIL cons0_extra actual=%h required=none", iaddr0);
            end else begin
               e = exp0.pop_front();
               check("cons0_addr", iaddr0, e.a);
               check("cons0_inst", inst0,  e.d);
            end
         end
         if (!rst && req0 && gnt0) begin
            if (expg0.size() == 0) begin
               total++; bad++;
               $display("FAIL gnt0_extra actual=%h required=none", addr0);
            end else begin
               ga = expg0.pop_front();
               check("gnt0_addr", addr0, ga);
            end
         end
         if (!rst1 && vld1) begin
            n_cons1++;
            if (exp1.size() == 0) begin
               total++; bad++;
               $display("FAIL cons1_extra actual=%h required=none", iaddr1);
            end else begin
               e = exp1.pop_front();
               check("cons1_addr", iaddr1, e.a);
               check("cons1_inst", inst1,  e.d);
            end
         end
         if (!rst1 && req1) begin
            if (expg1.size() == 0) begin
               total++; bad++;
               $display("FAIL gnt1_extra actual=%h required=none", addr1);
            end else begin
               ga = expg1.pop_front();
               check("gnt1_addr", addr1, ga);
            end
         end
      end
   end

   initial begin
      ent_t e1;
      rst = 1'b1; rst1 = 1'b1; hold = 1'b0; jump = 1'b0; jaddr = 32'h0; gnt0 = 1'b1; rlat = 1;
      repeat (3) tick();
      @(negedge clk);
      chk_rst0("reset0");

      // Straight-line fetch, then fill under hold, then jump+hold flush to 0x40.
      foreach (expg0[i]) expg0.delete(i);
      expg0 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44};
      push0(32'h0); push0(32'h4); push0(32'h8); push0(32'h40);
      tick(); rst = 1'b0;
      @(negedge clk);
      check("first_req", 32'(req0), 32'd1);
      check("first_addr", addr0, 32'h0);
      wait_cons(0, 3);
      hold = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      check("full_req", 32'(req0), 32'd0);
      check("full_vld", 32'(vld0), 32'd1);
      check("full_head_addr", iaddr0, 32'hC);
      check("full_head_inst", inst0, 32'h3);
      tick(); jump = 1'b1; jaddr = 32'h40;
      tick(); jump = 1'b0; hold = 1'b0;
      @(negedge clk);
      check("jh_vld", 32'(vld0), 32'd0);
      check("jh_req", 32'(req0), 32'd1);
      check("jh_addr", addr0, 32'h40);
      wait_cons(0, 4);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk_rst0("midrst0");

      // Hold from the first instruction for 6 cycles.
      expg0.push_back(32'h0); expg0.push_back(32'h4); expg0.push_back(32'h8); expg0.push_back(32'hC);
      push0(32'h0); push0(32'h4); push0(32'h8);
      tick(); tick(); rst = 1'b0; hold = 1'b1;
      tick(); tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("hold_vld", 32'(vld0), 32'd1);
         check("hold_addr", iaddr0, 32'h0);
         check("hold_inst", inst0, 32'h0);
         if (i >= 2) check("hold_req", 32'(req0), 32'd0);
         tick();
      end
      hold = 1'b0;
      wait_cons(0, 7);
      rst = 1'b1;

      // Jump to 0x103 while the 0x8 fetch is outstanding (3-cycle bus).
      expg0.push_back(32'h0); expg0.push_back(32'h4); expg0.push_back(32'h8);
      expg0.push_back(32'h100); expg0.push_back(32'h104);
      push0(32'h0); push0(32'h4); push0(32'h100);
      tick(); rlat = 3;
      tick(); tick(); rst = 1'b0;
      wait_cons(0, 9);
      jump = 1'b1; jaddr = 32'h103;
      tick(); jump = 1'b0;
      @(negedge clk);
      check("drop_wait_req", 32'(req0), 32'd0);
      check("drop_vld", 32'(vld0), 32'd0);
      tick(); tick();
      @(negedge clk);
      check("redir_req", 32'(req0), 32'd1);
      check("redir_addr", addr0, 32'h100);
      wait_cons(0, 10);
      rst = 1'b1;

      // Delayed grant, then jump over a pending ungranted request.
      expg0.push_back(32'h0); expg0.push_back(32'h80); expg0.push_back(32'h84);
      push0(32'h0); push0(32'h80);
      tick(); rlat = 1; gnt0 = 1'b0;
      tick(); tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("nogrant_req", 32'(req0), 32'd1);
         check("nogrant_addr", addr0, 32'h0);
         tick();
      end
      gnt0 = 1'b1;
      tick(); gnt0 = 1'b0;
      tick();
      @(negedge clk);
      check("next_req", 32'(req0), 32'd1);
      check("next_addr", addr0, 32'h4);
      tick(); jump = 1'b1; jaddr = 32'h80;
      @(negedge clk);
      check("withdraw_req", 32'(req0), 32'd0);
      tick(); jump = 1'b0; gnt0 = 1'b1;
      @(negedge clk);
      check("rereq_req", 32'(req0), 32'd1);
      check("rereq_addr", addr0, 32'h80);
      wait_cons(0, 12);
      rst = 1'b1;

      // RESET_PC near the top of the address space: fetch wraps to 0.
      @(negedge clk);
      chk_rst1("reset1");
      expg1.push_back(32'hFFFF_FFFC); expg1.push_back(32'h0); expg1.push_back(32'h4);
      e1.a = 32'hFFFF_FFFC; e1.d = 32'h3FFF_FFFF; exp1.push_back(e1);
      e1.a = 32'h0;         e1.d = 32'h0;         exp1.push_back(e1);
      tick(); rst1 = 1'b0;
      @(negedge clk);
      check("wrap_first_req", 32'(req1), 32'd1);
      check("wrap_first_addr", addr1, 32'hFFFF_FFFC);
      wait_cons(1, 2);
      rst1 = 1'b1;
      tick();
      @(negedge clk);
      chk_rst1("midrst1");

      repeat (3) tick();
      check("exp0_left", 32'(exp0.size()), 32'd0);
      check("expg0_left", 32'(expg0.size()), 32'd0);
      check("exp1_left", 32'(exp1.size()), 32'd0);
      check("expg1_left", 32'(expg1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
